// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite slave over a local byte-addressable SRAM with programmable wait states
module ahb_lite_sram_slave #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned WORDS = 2 ** (ADDR_W - 2);
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_ERR1   = 3'd3,
    S_ERR2   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;

  logic [31:0]       mem [WORDS];

  logic              accept;
  logic              in_window;
  logic              addr_err;
  logic              mem_we;
  logic [3:0]        byte_en;

  // HBURST and the BUSY/IDLE distinction carry no meaning for this slave
  logic              unused_ok;
  assign unused_ok = &{1'b0, HBURST, HTRANS[0]};

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign in_window = (HADDR[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
  assign addr_err  = (HSIZE > 3'd2)
                   | ((HSIZE == 3'd1) & HADDR[0])
                   | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                   | ~in_window;

  // State and latched address-phase registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Next state: IDLE, ACCESS and ERR2 all accept a new address phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_ACCESS;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (accept) begin
          addr_d  = HADDR[ADDR_W-1:0];
          write_d = HWRITE;
          size_d  = HSIZE[1:0];
          if (addr_err) begin
            state_d = S_ERR1;
          end else if (WS == 3'd0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Bus responses, read data and byte-lane write enables per state
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'd0;
    mem_we    = 1'b0;
    byte_en   = 4'b0000;
    case (state_q)
      S_WAIT: HREADYOUT = 1'b0;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      S_ACCESS: begin
        if (write_q) begin
          mem_we = 1'b1;
          case (size_q)
            2'd0:    byte_en = 4'b0001 << addr_q[1:0];
            2'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
          endcase
        end else begin
          HRDATA = mem[addr_q[ADDR_W-1:2]];
        end
      end
      default: ;
    endcase
  end

  // Memory array is not reset; writes commit at the closing edge of ACCESS
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - self-checking bench for ahb_lite_sram_slave (WAIT_STATES 1, 0 and 3)
module tb_ahb_lite_sram_slave;

  localparam int MEM_BYTES = 1024;

  logic        clk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        force_low;
  int          cur;

  logic [31:0] hrdata_w    [3];
  logic        hreadyout_w [3];
  logic        hresp_w     [3];
  logic        hready;

  int ws_tab [3] = '{1, 0, 3};

  assign hready = force_low ? 1'b0 : hreadyout_w[cur];

  ahb_lite_sram_slave #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_ws1 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel && cur == 0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(hready), .HWDATA(hwdata),
    .HRDATA(hrdata_w[0]), .HREADYOUT(hreadyout_w[0]), .HRESP(hresp_w[0]));

  ahb_lite_sram_slave #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel && cur == 1), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(hready), .HWDATA(hwdata),
    .HRDATA(hrdata_w[1]), .HREADYOUT(hreadyout_w[1]), .HRESP(hresp_w[1]));

  ahb_lite_sram_slave #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel && cur == 2), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(hready), .HWDATA(hwdata),
    .HRDATA(hrdata_w[2]), .HREADYOUT(hreadyout_w[2]), .HRESP(hresp_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] refm [3][MEM_BYTES];

  typedef struct {
    int          d;
    logic [31:0] a;
    logic        w;
    logic [2:0]  s;
    logic [31:0] wd;
    logic        err;
    int          nw;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    haddr  = 32'd0;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hburst = 3'd0;
    htrans = 2'b00;
  endtask

  // One non-pipelined transfer; called and returns at #1 after a rising edge
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [2:0] s,
                      input logic [31:0] wd, output logic [31:0] rd, output logic resp,
                      output int nwait, output logic low_resp);
    bit done;
    cur    = d;
    hsel   = 1'b1;
    haddr  = a;
    hwrite = w;
    hsize  = s;
    hburst = 3'd0;
    htrans = 2'b10;
    @(posedge clk); #1;
    bus_idle();
    hwdata   = wd;
    nwait    = 0;
    low_resp = 1'b0;
    rd       = 32'd0;
    resp     = 1'b0;
    done     = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!hready) begin
        nwait++;
        low_resp = low_resp | hresp_w[d];
      end else begin
        rd   = hrdata_w[d];
        resp = hresp_w[d];
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("xfer_timeout", 32'(done), 32'd1);
    hwdata = 32'd0;
  endtask

  task automatic do_check(input string tag, input int d, input logic [31:0] a, input logic w,
                          input logic [2:0] s, input logic [31:0] wd, input logic err,
                          input int nw, input logic [31:0] erd);
    logic [31:0] rd;
    logic        resp, lr;
    int          n;
    xfer(d, a, w, s, wd, rd, resp, n, lr);
    check({tag, "_resp"}, 32'(resp), 32'(err));
    check({tag, "_lowresp"}, 32'(lr), 32'(err));
    check({tag, "_nwait"}, n, nw);
    check({tag, "_rdata"}, rd, erd);
  endtask

  function automatic bit ref_err(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    if (a % (32'd1 << s) != 0) return 1'b1;
    return !(a < MEM_BYTES);
  endfunction

  function automatic logic [31:0] ref_word(input int d, input logic [31:0] a);
    int wa;
    wa = int'(a) / 4 * 4;
    return {refm[d][wa+3], refm[d][wa+2], refm[d][wa+1], refm[d][wa]};
  endfunction

  task automatic ref_write(input int d, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    int b;
    for (int k = 0; k < (1 << s); k++) begin
      b = int'(a) + k;
      refm[d][b] = wd[8*(b%4) +: 8];
    end
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic        resp, lr, w, e;
    logic [2:0]  s;
    int          n, d;

    vt[0]  = '{0, 32'h010, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 1, 32'h0};
    vt[1]  = '{0, 32'h010, 1'b0, 3'd2, 32'h0,        1'b0, 1, 32'hDEADBEEF};
    vt[2]  = '{0, 32'h013, 1'b1, 3'd0, 32'hA5000000, 1'b0, 1, 32'h0};
    vt[3]  = '{0, 32'h010, 1'b1, 3'd1, 32'h00001234, 1'b0, 1, 32'h0};
    vt[4]  = '{0, 32'h010, 1'b0, 3'd2, 32'h0,        1'b0, 1, 32'hA5AD1234};
    vt[5]  = '{0, 32'h000, 1'b1, 3'd2, 32'h01234567, 1'b0, 1, 32'h0};
    vt[6]  = '{0, 32'h002, 1'b0, 3'd2, 32'h0,        1'b1, 1, 32'h0};
    vt[7]  = '{0, 32'h400, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1, 1, 32'h0};
    vt[8]  = '{0, 32'h000, 1'b0, 3'd2, 32'h0,        1'b0, 1, 32'h01234567};
    vt[9]  = '{0, 32'h011, 1'b1, 3'd1, 32'hFFFFFFFF, 1'b1, 1, 32'h0};
    vt[10] = '{0, 32'h010, 1'b1, 3'd3, 32'hFFFFFFFF, 1'b1, 1, 32'h0};
    vt[11] = '{0, 32'h012, 1'b0, 3'd1, 32'h0,        1'b0, 1, 32'hA5AD1234};
    vt[12] = '{2, 32'h3FC, 1'b1, 3'd2, 32'h11223344, 1'b0, 3, 32'h0};
    vt[13] = '{2, 32'h3FE, 1'b1, 3'd1, 32'hBEEF0000, 1'b0, 3, 32'h0};
    vt[14] = '{2, 32'h3FC, 1'b0, 3'd2, 32'h0,        1'b0, 3, 32'hBEEF3344};
    vt[15] = '{1, 32'h008, 1'b1, 3'd2, 32'hCAFEF00D, 1'b0, 0, 32'h0};
    vt[16] = '{1, 32'h008, 1'b0, 3'd2, 32'h0,        1'b0, 0, 32'hCAFEF00D};
    vt[17] = '{1, 32'hFFFFFFFC, 1'b0, 3'd2, 32'h0,   1'b1, 1, 32'h0};

    // reset state
    cur       = 0;
    force_low = 1'b0;
    hwdata    = 32'd0;
    hresetn   = 1'b0;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_hreadyout%0d", i), 32'(hreadyout_w[i]), 32'd1);
      check($sformatf("reset_hresp%0d", i), 32'(hresp_w[i]), 32'd0);
      check($sformatf("reset_hrdata%0d", i), hrdata_w[i], 32'd0);
    end
    hresetn = 1'b1;
    @(posedge clk); #1;

    // table-driven vectors
    for (int i = 0; i < 18; i++) begin
      do_check($sformatf("vec%0d", i), vt[i].d, vt[i].a, vt[i].w, vt[i].s, vt[i].wd,
               vt[i].err, vt[i].nw, vt[i].rd);
    end

    // zero-wait INCR4 write burst then read burst, fully pipelined
    cur = 1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        hsel   = 1'b1;
        htrans = (i % 4 == 0) ? 2'b10 : 2'b11;
        haddr  = 32'h20 + 32'(4 * (i % 4));
        hwrite = (i < 4);
        hsize  = 3'd2;
        hburst = 3'b011;
      end else begin
        bus_idle();
      end
      hwdata = (i >= 1 && i <= 4) ? 32'(i) : 32'd0;
      @(negedge clk);
      check($sformatf("burst_hreadyout%0d", i), 32'(hreadyout_w[1]), 32'd1);
      check($sformatf("burst_hresp%0d", i), 32'(hresp_w[1]), 32'd0);
      if (i >= 5) check($sformatf("burst_rdata%0d", i), hrdata_w[1], 32'(i - 4));
      @(posedge clk); #1;
    end
    hwdata = 32'd0;

    // IDLE, BUSY, deselected NONSEQ and foreign HREADY low: no transfer
    cur = 0;
    for (int i = 0; i < 4; i++) begin
      hsel      = (i != 2);
      htrans    = (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b10;
      haddr     = 32'h10;
      hwrite    = 1'b1;
      hsize     = 3'd2;
      force_low = (i == 3);
      hwdata    = 32'hFFFFFFFF;
      @(negedge clk);
      check($sformatf("noxfer_hreadyout%0d", i), 32'(hreadyout_w[0]), 32'd1);
      check($sformatf("noxfer_hresp%0d", i), 32'(hresp_w[0]), 32'd0);
      @(posedge clk); #1;
    end
    force_low = 1'b0;
    bus_idle();
    @(negedge clk);
    check("noxfer_after_hreadyout", 32'(hreadyout_w[0]), 32'd1);
    @(posedge clk); #1;
    hwdata = 32'd0;
    do_check("noxfer_read", 0, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 1, 32'hA5AD1234);

    // reset during the second wait cycle drops the pending write
    xfer(2, 32'h40, 1'b1, 3'd2, 32'h11112222, rd, resp, n, lr);
    hsel   = 1'b1;
    haddr  = 32'h40;
    hwrite = 1'b1;
    hsize  = 3'd2;
    htrans = 2'b10;
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'h55AA55AA;
    @(negedge clk);
    check("rst_wait1_hreadyout", 32'(hreadyout_w[2]), 32'd0);
    @(posedge clk); #2;
    hresetn = 1'b0;
    #1;
    check("rst_async_hreadyout", 32'(hreadyout_w[2]), 32'd1);
    check("rst_async_hresp", 32'(hresp_w[2]), 32'd0);
    check("rst_async_hrdata", hrdata_w[2], 32'd0);
    @(negedge clk);
    hresetn = 1'b1;
    @(posedge clk); #1;
    hwdata = 32'd0;
    do_check("rst_read", 2, 32'h40, 1'b0, 3'd2, 32'h0, 1'b0, 3, 32'h11112222);

    // preload every word of every instance so the reference model is fully known
    for (int dd = 0; dd < 3; dd++) begin
      for (int wi = 0; wi < MEM_BYTES / 4; wi++) begin
        wd = $urandom;
        xfer(dd, 32'(wi * 4), 1'b1, 3'd2, wd, rd, resp, n, lr);
        ref_write(dd, 32'(wi * 4), 3'd2, wd);
      end
    end

    // randomized transfers against the reference model
    for (int i = 0; i < 300; i++) begin
      d  = $urandom_range(0, 2);
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      s  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 7) == 0) a = a + 32'(MEM_BYTES) + ($urandom_range(0, 1) == 0 ? 32'd0 : 32'hFFFF0000);
      if (s <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
      e = ref_err(a, s);
      do_check($sformatf("rnd%0d", i), d, a, w, s, wd, e, e ? 1 : ws_tab[d],
               (!w && !e) ? ref_word(d, a) : 32'd0);
      if (w && !e) ref_write(d, a, s, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
